uart_frame_decoder: RTL and testbench
=====================================

UART_FRAME_DECODER -- requirements
Module: uart_frame_decoder

Interface
REQ-001 Parameter DATA_W, default 8: width of one received UART byte.
REQ-002 Parameter OP_W, default 3: opcode width in read_data[OP_W-1:0]; payload PL_W = DATA_W-OP_W sits in read_data[DATA_W-1:OP_W].
REQ-003 Parameter POS_W, default 10: width of each assembled position field; legal only if PL_W < POS_W <= 2*PL_W.
REQ-004 Parameter SCORE_W, default 3: opponent score width; legal only if SCORE_W <= PL_W-2.
REQ-005 Parameter TIMEOUT_CYC, default 1000000: idle cycles after which the link is declared lost.
REQ-006 Port clk  in  1: single clock; all state changes on its rising edge.
REQ-007 Port rst_n  in  1: reset, asynchronous, active-low.
REQ-008 Ports read_data (in, DATA_W) and rx_empty (in, 1): head of a first-word-fall-through RX FIFO; read_data is valid while rx_empty=0.
REQ-009 Port rd_uart  out  1: one-cycle pop strobe to the RX FIFO.
REQ-010 Ports connect_corrected, enemy_shooter, game_starts  out  1 each: link and session flags.
REQ-011 Ports keeper_pos, x_shooter, y_shooter  out  POS_W each: committed opponent positions.
REQ-012 Ports opponent_score (out, SCORE_W), enemy_is_scored (out, 1), enemy_input (out, 1): opponent status.
REQ-013 Ports keeper_upd and shot_upd  out  1 each: one-cycle pulses, high in the cycle their field changes.
REQ-014 Ports link_lost (out, 1, one-cycle pulse) and err_cnt (out, 8, saturating count of protocol errors).

Function
REQ-015 FSM states IDLE, POP, SETTLE; IDLE->POP when rx_empty=0; POP->SETTLE unconditionally; SETTLE->IDLE unconditionally.
REQ-016 rd_uart is 1 only in POP; exactly one pop per byte; sustained throughput is one byte per 3 cycles.
REQ-017 The byte is decoded from read_data as sampled in POP; affected outputs and pulses appear in the cycle after POP.
REQ-018 Opcode 0 (sync): payload 5'b11001 -> connect=1, shooter=1, starts=1; 5'b01001 -> 1,0,1; 5'b00001 -> 1,0,0; any other -> 0,0,0 and err_cnt+1.
REQ-019 Opcode 1 stores payload into keeper-low holding register and sets keeper_pend; a repeated opcode 1 overwrites it.
REQ-020 Opcode 2 with keeper_pend=1: keeper_pos = {payload, keeper_low} truncated to POS_W, keeper_upd pulses, keeper_pend clears; with keeper_pend=0: byte discarded, err_cnt+1.
REQ-021 Opcodes 3, 4, 5 store x-low, x-high, y-low and set per-fragment pending bits; repeats overwrite.
REQ-022 Opcode 6 with all three shot pending bits set: x_shooter and y_shooter update in the same cycle, shot_upd pulses, all three bits clear; otherwise byte discarded, shot pending bits cleared, err_cnt+1.
REQ-023 Opcode 2^OP_W-1 (status): opponent_score = payload[SCORE_W-1:0], enemy_is_scored = payload[PL_W-2], enemy_input = payload[PL_W-1].
REQ-024 Any other opcode value (OP_W>3 only): byte discarded, connect_corrected=0, err_cnt+1.
REQ-025 Idle counter clears on every POP, otherwise increments, saturating at TIMEOUT_CYC.
REQ-026 On the increment that reaches TIMEOUT_CYC: connect_corrected, game_starts, enemy_shooter clear, all pending bits clear, link_lost pulses once; no further pulses until a byte is popped.
REQ-027 err_cnt saturates at 255; it does not wrap.
REQ-028 A byte is never lost or popped twice; rx_empty changes outside IDLE are ignored.

Reset
REQ-029 While rst_n=0: FSM in IDLE, every output 0, err_cnt 0, idle counter 0, all holding registers and pending bits 0.
REQ-030 Reset assertion mid-sequence (any state) discards partial fragments; after release, the first pop occurs no earlier than the second rising edge of clk.

Verification
REQ-031 Sync byte 8'b11001_000 -> one rd_uart pulse; next cycle connect=1, shooter=1, starts=1.
REQ-032 Bytes {10101,001}, {00011,010} -> keeper_pos=10'b0001110101 (117), keeper_upd single pulse; lone opcode 2 -> keeper_pos unchanged, err_cnt 1.
REQ-033 Opcodes 3,4,5,6 carrying x=300 and y=400 -> both fields update in one cycle, shot_upd one pulse; sequence 3,5,6 (no 4) -> no update, err_cnt+1.
REQ-034 Status byte {1,0,101,111} -> enemy_input=1, enemy_is_scored=0, opponent_score=5.
REQ-035 TIMEOUT_CYC=16, connected, no traffic -> link_lost one pulse at idle count 16, connect=0; next sync byte restores connect=1.
REQ-036 Continuous non-empty FIFO holding 6 bytes -> exactly 6 rd_uart pulses, spaced 3 cycles; rst_n low for one cycle during byte 3 -> all outputs 0, no spurious update pulses.

Source files
------------

// File: rtl/uart_frame_decoder.sv
// Pops bytes from a first-word-fall-through RX FIFO, reassembles split position
// fields and tracks opponent link, session and status with an idle watchdog.
module uart_frame_decoder #(
    parameter int DATA_W      = 8,
    parameter int OP_W        = 3,
    parameter int POS_W       = 10,
    parameter int SCORE_W     = 3,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DATA_W-1:0]  read_data,
    input  logic               rx_empty,
    output logic               rd_uart,
    output logic               connect_corrected,
    output logic               enemy_shooter,
    output logic               game_starts,
    output logic [POS_W-1:0]   keeper_pos,
    output logic [POS_W-1:0]   x_shooter,
    output logic [POS_W-1:0]   y_shooter,
    output logic [SCORE_W-1:0] opponent_score,
    output logic               enemy_is_scored,
    output logic               enemy_input,
    output logic               keeper_upd,
    output logic               shot_upd,
    output logic               link_lost,
    output logic [7:0]         err_cnt
);
    localparam int PL_W  = DATA_W - OP_W;
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [OP_W-1:0] OP_SYNC   = OP_W'(0);
    localparam logic [OP_W-1:0] OP_KLO    = OP_W'(1);
    localparam logic [OP_W-1:0] OP_KHI    = OP_W'(2);
    localparam logic [OP_W-1:0] OP_XLO    = OP_W'(3);
    localparam logic [OP_W-1:0] OP_XHI    = OP_W'(4);
    localparam logic [OP_W-1:0] OP_YLO    = OP_W'(5);
    localparam logic [OP_W-1:0] OP_SHOT   = OP_W'(6);
    localparam logic [OP_W-1:0] OP_STATUS = {OP_W{1'b1}};

    localparam logic [PL_W-1:0] SYNC_FULL  = PL_W'(5'b11001);
    localparam logic [PL_W-1:0] SYNC_GUEST = PL_W'(5'b01001);
    localparam logic [PL_W-1:0] SYNC_LINK  = PL_W'(5'b00001);

    localparam logic [CNT_W-1:0] IDLE_MAX = CNT_W'(TIMEOUT_CYC);

    typedef enum logic [1:0] {IDLE, POP, SETTLE} state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0]   idleCnt_q, idleCnt_d;
    logic               connect_q, connect_d;
    logic               shooter_q, shooter_d;
    logic               starts_q, starts_d;
    logic [POS_W-1:0]   keeperPos_q, keeperPos_d;
    logic [POS_W-1:0]   xPos_q, xPos_d;
    logic [POS_W-1:0]   yPos_q, yPos_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               scored_q, scored_d;
    logic               input_q, input_d;
    logic [7:0]         errCnt_q, errCnt_d;
    logic               keeperUpd_q, keeperUpd_d;
    logic               shotUpd_q, shotUpd_d;
    logic               linkLost_q, linkLost_d;
    logic [PL_W-1:0]    keeperLow_q, keeperLow_d;
    logic [PL_W-1:0]    xLow_q, xLow_d;
    logic [PL_W-1:0]    xHigh_q, xHigh_d;
    logic [PL_W-1:0]    yLow_q, yLow_d;
    logic               keeperPend_q, keeperPend_d;
    logic               xLowPend_q, xLowPend_d;
    logic               xHighPend_q, xHighPend_d;
    logic               yLowPend_q, yLowPend_d;

    logic [OP_W-1:0]   opcode;
    logic [PL_W-1:0]   payload;
    logic [2*PL_W-1:0] keeperCat, xCat, yCat;
    logic              errInc;
    logic              lostNow;

    assign opcode    = read_data[OP_W-1:0];
    assign payload   = read_data[DATA_W-1:OP_W];
    assign keeperCat = {payload, keeperLow_q};
    assign xCat      = {xHigh_q, xLow_q};
    assign yCat      = {payload, yLow_q};

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!rx_empty) state_d = POP;
            POP:     state_d = SETTLE;
            SETTLE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The watchdog saturates, so link_lost can fire only once per silent stretch.
    always_comb begin
        idleCnt_d = idleCnt_q;
        lostNow   = 1'b0;
        if (state_q == POP) begin
            idleCnt_d = '0;
        end else if (idleCnt_q != IDLE_MAX) begin
            idleCnt_d = idleCnt_q + CNT_W'(1);
            lostNow   = (idleCnt_q == IDLE_MAX - CNT_W'(1));
        end
    end

    always_comb begin
        connect_d    = connect_q;
        shooter_d    = shooter_q;
        starts_d     = starts_q;
        keeperPos_d  = keeperPos_q;
        xPos_d       = xPos_q;
        yPos_d       = yPos_q;
        score_d      = score_q;
        scored_d     = scored_q;
        input_d      = input_q;
        keeperLow_d  = keeperLow_q;
        xLow_d       = xLow_q;
        xHigh_d      = xHigh_q;
        yLow_d       = yLow_q;
        keeperPend_d = keeperPend_q;
        xLowPend_d   = xLowPend_q;
        xHighPend_d  = xHighPend_q;
        yLowPend_d   = yLowPend_q;
        keeperUpd_d  = 1'b0;
        shotUpd_d    = 1'b0;
        linkLost_d   = lostNow;
        errInc       = 1'b0;

        if (state_q == POP) begin
            case (opcode)
                OP_SYNC: begin
                    connect_d = 1'b1;
                    shooter_d = 1'b0;
                    starts_d  = 1'b0;
                    if (payload == SYNC_FULL) begin
                        shooter_d = 1'b1;
                        starts_d  = 1'b1;
                    end else if (payload == SYNC_GUEST) begin
                        starts_d = 1'b1;
                    end else if (payload != SYNC_LINK) begin
                        connect_d = 1'b0;
                        errInc    = 1'b1;
                    end
                end
                OP_KLO: begin
                    keeperLow_d  = payload;
                    keeperPend_d = 1'b1;
                end
                OP_KHI: begin
                    if (keeperPend_q) begin
                        keeperPos_d  = keeperCat[POS_W-1:0];
                        keeperUpd_d  = 1'b1;
                        keeperPend_d = 1'b0;
                    end else begin
                        errInc = 1'b1;
                    end
                end
                OP_XLO: begin
                    xLow_d     = payload;
                    xLowPend_d = 1'b1;
                end
                OP_XHI: begin
                    xHigh_d     = payload;
                    xHighPend_d = 1'b1;
                end
                OP_YLO: begin
                    yLow_d     = payload;
                    yLowPend_d = 1'b1;
                end
                OP_SHOT: begin
                    // An incomplete shot is dropped whole so stale fragments never mix.
                    if (xLowPend_q && xHighPend_q && yLowPend_q) begin
                        xPos_d    = xCat[POS_W-1:0];
                        yPos_d    = yCat[POS_W-1:0];
                        shotUpd_d = 1'b1;
                    end else begin
                        errInc = 1'b1;
                    end
                    xLowPend_d  = 1'b0;
                    xHighPend_d = 1'b0;
                    yLowPend_d  = 1'b0;
                end
                OP_STATUS: begin
                    score_d  = payload[SCORE_W-1:0];
                    scored_d = payload[PL_W-2];
                    input_d  = payload[PL_W-1];
                end
                default: begin
                    connect_d = 1'b0;
                    errInc    = 1'b1;
                end
            endcase
        end

        if (lostNow) begin
            connect_d    = 1'b0;
            shooter_d    = 1'b0;
            starts_d     = 1'b0;
            keeperPend_d = 1'b0;
            xLowPend_d   = 1'b0;
            xHighPend_d  = 1'b0;
            yLowPend_d   = 1'b0;
        end

        errCnt_d = (errInc && errCnt_q != 8'hFF) ? errCnt_q + 8'd1 : errCnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idleCnt_q    <= '0;
            connect_q    <= 1'b0;
            shooter_q    <= 1'b0;
            starts_q     <= 1'b0;
            keeperPos_q  <= '0;
            xPos_q       <= '0;
            yPos_q       <= '0;
            score_q      <= '0;
            scored_q     <= 1'b0;
            input_q      <= 1'b0;
            errCnt_q     <= '0;
            keeperUpd_q  <= 1'b0;
            shotUpd_q    <= 1'b0;
            linkLost_q   <= 1'b0;
            keeperLow_q  <= '0;
            xLow_q       <= '0;
            xHigh_q      <= '0;
            yLow_q       <= '0;
            keeperPend_q <= 1'b0;
            xLowPend_q   <= 1'b0;
            xHighPend_q  <= 1'b0;
            yLowPend_q   <= 1'b0;
        end else begin
            idleCnt_q    <= idleCnt_d;
            connect_q    <= connect_d;
            shooter_q    <= shooter_d;
            starts_q     <= starts_d;
            keeperPos_q  <= keeperPos_d;
            xPos_q       <= xPos_d;
            yPos_q       <= yPos_d;
            score_q      <= score_d;
            scored_q     <= scored_d;
            input_q      <= input_d;
            errCnt_q     <= errCnt_d;
            keeperUpd_q  <= keeperUpd_d;
            shotUpd_q    <= shotUpd_d;
            linkLost_q   <= linkLost_d;
            keeperLow_q  <= keeperLow_d;
            xLow_q       <= xLow_d;
            xHigh_q      <= xHigh_d;
            yLow_q       <= yLow_d;
            keeperPend_q <= keeperPend_d;
            xLowPend_q   <= xLowPend_d;
            xHighPend_q  <= xHighPend_d;
            yLowPend_q   <= yLowPend_d;
        end
    end

    assign rd_uart           = (state_q == POP);
    assign connect_corrected = connect_q;
    assign enemy_shooter     = shooter_q;
    assign game_starts       = starts_q;
    assign keeper_pos        = keeperPos_q;
    assign x_shooter         = xPos_q;
    assign y_shooter         = yPos_q;
    assign opponent_score    = score_q;
    assign enemy_is_scored   = scored_q;
    assign enemy_input       = input_q;
    assign keeper_upd        = keeperUpd_q;
    assign shot_upd          = shotUpd_q;
    assign link_lost         = linkLost_q;
    assign err_cnt           = errCnt_q;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Scoreboard bench for uart_frame_decoder: a byte-level reference model queues the
// expected outputs per byte/timeout and a monitor compares them as the DUT presents them.
module tb_uart_frame_decoder;
    localparam int DATA_W      = 8;
    localparam int OP_W        = 3;
    localparam int POS_W       = 10;
    localparam int SCORE_W     = 3;
    localparam int TIMEOUT_CYC = 16;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [DATA_W-1:0]  read_data = '0;
    logic               rx_empty = 1'b1;
    logic               rd_uart;
    logic               connect_corrected, enemy_shooter, game_starts;
    logic [POS_W-1:0]   keeper_pos, x_shooter, y_shooter;
    logic [SCORE_W-1:0] opponent_score;
    logic               enemy_is_scored, enemy_input, keeper_upd, shot_upd, link_lost;
    logic [7:0]         err_cnt;

    always #5 clk = ~clk;

    uart_frame_decoder #(
        .DATA_W(DATA_W), .OP_W(OP_W), .POS_W(POS_W),
        .SCORE_W(SCORE_W), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .read_data(read_data), .rx_empty(rx_empty),
        .rd_uart(rd_uart), .connect_corrected(connect_corrected),
        .enemy_shooter(enemy_shooter), .game_starts(game_starts),
        .keeper_pos(keeper_pos), .x_shooter(x_shooter), .y_shooter(y_shooter),
        .opponent_score(opponent_score), .enemy_is_scored(enemy_is_scored),
        .enemy_input(enemy_input), .keeper_upd(keeper_upd), .shot_upd(shot_upd),
        .link_lost(link_lost), .err_cnt(err_cnt)
    );

    typedef struct packed {
        logic       lost;
        logic       conn;
        logic       shoot;
        logic       start;
        logic [9:0] keeper;
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] score;
        logic       scored;
        logic       inp;
        logic [7:0] err;
        logic       kupd;
        logic       supd;
    } outs_t;

    outs_t      expQ[$];
    logic [7:0] fifoQ[$];
    logic [7:0] stim[$];
    int         popLog[$];
    int         cycle = 0;
    int         lastPopCycle = 0;
    int         checks = 0;
    int         passes = 0;

    // Reference model state, kept as plain integers.
    bit mConn, mShoot, mStart, mScored, mInput;
    int mKeeper, mX, mY, mScore, mErr;
    int kLow, xLo, xHi, yLo;
    bit kPend, xLoP, xHiP, yLoP;

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: actual %0h, expected %0h", name, act, exp);
    endtask

    function automatic outs_t sampleOut();
        outs_t s;
        s.lost = link_lost;       s.conn = connect_corrected;
        s.shoot = enemy_shooter;  s.start = game_starts;
        s.keeper = keeper_pos;    s.x = x_shooter;          s.y = y_shooter;
        s.score = opponent_score; s.scored = enemy_is_scored;
        s.inp = enemy_input;      s.err = err_cnt;
        s.kupd = keeper_upd;      s.supd = shot_upd;
        return s;
    endfunction

    function automatic void modelReset();
        mConn = 0; mShoot = 0; mStart = 0; mScored = 0; mInput = 0;
        mKeeper = 0; mX = 0; mY = 0; mScore = 0; mErr = 0;
        kLow = 0; xLo = 0; xHi = 0; yLo = 0;
        kPend = 0; xLoP = 0; xHiP = 0; yLoP = 0;
    endfunction

    function automatic outs_t modelSnapshot(input bit lost, input bit ku, input bit su);
        outs_t s;
        s.lost = lost;  s.conn = mConn;  s.shoot = mShoot;  s.start = mStart;
        s.keeper = 10'(mKeeper);  s.x = 10'(mX);  s.y = 10'(mY);
        s.score = 3'(mScore);  s.scored = mScored;  s.inp = mInput;
        s.err = 8'(mErr);  s.kupd = ku;  s.supd = su;
        return s;
    endfunction

    function automatic void modelByte(input logic [7:0] b);
        int op, pl;
        bit ku, su, bad;
        op = int'(b) % 8;
        pl = int'(b) / 8;
        ku = 0; su = 0; bad = 0;
        case (op)
            0: begin
                if (pl == 25)     begin mConn = 1; mShoot = 1; mStart = 1; end
                else if (pl == 9) begin mConn = 1; mShoot = 0; mStart = 1; end
                else if (pl == 1) begin mConn = 1; mShoot = 0; mStart = 0; end
                else begin mConn = 0; mShoot = 0; mStart = 0; bad = 1; end
            end
            1: begin kLow = pl; kPend = 1; end
            2: begin
                if (kPend) begin mKeeper = (pl * 32 + kLow) % 1024; ku = 1; kPend = 0; end
                else bad = 1;
            end
            3: begin xLo = pl; xLoP = 1; end
            4: begin xHi = pl; xHiP = 1; end
            5: begin yLo = pl; yLoP = 1; end
            6: begin
                if (xLoP && xHiP && yLoP) begin
                    mX = (xHi * 32 + xLo) % 1024;
                    mY = (pl * 32 + yLo) % 1024;
                    su = 1;
                end else bad = 1;
                xLoP = 0; xHiP = 0; yLoP = 0;
            end
            default: begin mScore = pl % 8; mScored = ((pl / 8) % 2) == 1; mInput = (pl / 16) == 1; end
        endcase
        if (bad && mErr < 255) mErr++;
        expQ.push_back(modelSnapshot(0, ku, su));
    endfunction

    function automatic void modelTimeout();
        mConn = 0; mShoot = 0; mStart = 0;
        kPend = 0; xLoP = 0; xHiP = 0; yLoP = 0;
        expQ.push_back(modelSnapshot(1, 0, 0));
    endfunction

    task automatic addByte(input int op, input int pl);
        stim.push_back(8'(((pl % 32) * 8) + (op % 8)));
    endtask

    task automatic pushBytes();
        @(posedge clk); #2;
        foreach (stim[i]) begin
            modelByte(stim[i]);
            fifoQ.push_back(stim[i]);
        end
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while ((fifoQ.size() != 0 || expQ.size() != 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (n >= budget) begin
            checks++;
            $display("[TB] FAIL drain: fifo %0d bytes, %0d expected outputs left after %0d cycles", fifoQ.size(), expQ.size(), n);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus();
        pushBytes();
        waitDrain(3 * stim.size() + 30);
    endtask

    // FIFO model: a pop is taken on the edge that ends a cycle where rd_uart was high.
    initial begin
        bit rdSeen;
        forever begin
            @(negedge clk);
            rdSeen = rd_uart;
            @(posedge clk);
            cycle++;
            if (rdSeen) begin
                lastPopCycle = cycle;
                popLog.push_back(cycle);
                if (fifoQ.size() > 0) void'(fifoQ.pop_front());
            end
            #1;
            rx_empty = (fifoQ.size() == 0);
            read_data = rx_empty ? 8'($urandom) : fifoQ[0];
        end
    end

    // Monitor: the cycle after a pop and any link_lost pulse each consume one expectation.
    initial begin
        bit prevRd;
        outs_t act, exp;
        prevRd = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prevRd = 0;
            end else begin
                act = sampleOut();
                if (prevRd || link_lost) begin
                    if (expQ.size() == 0) begin
                        checks++;
                        $display("[TB] FAIL unexpected output: actual %h, nothing expected", act);
                    end else begin
                        exp = expQ.pop_front();
                        checkVal(prevRd ? "byte outputs" : "timeout outputs", 64'(act), 64'(exp));
                        if (link_lost) checkVal("timeout idle count", 64'(cycle - lastPopCycle), 64'(TIMEOUT_CYC));
                    end
                end else if (keeper_upd || shot_upd) begin
                    checks++;
                    $display("[TB] FAIL stray pulse: actual keeper_upd=%0b shot_upd=%0b, expected 0", keeper_upd, shot_upd);
                end
                prevRd = rd_uart;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int base, badGap, r, s, items;
        modelReset();
        repeat (3) @(posedge clk);
        #2;
        checkVal("reset outputs", 64'(sampleOut()), 64'(0));
        checkVal("reset rd_uart", 64'(rd_uart), 64'(0));

        // Full sync byte waiting in the FIFO while still in reset.
        base = popLog.size();
        stim.delete(); stim.push_back(8'b11001_000);
        pushBytes();
        repeat (2) @(posedge clk);
        #2;
        checkVal("no pop in reset", 64'(rd_uart), 64'(0));
        rst_n = 1'b1;
        waitDrain(40);
        checkVal("sync pop count", 64'(popLog.size() - base), 64'(1));
        checkVal("sync flags", 64'({connect_corrected, enemy_shooter, game_starts}), 64'(3'b111));

        stim.delete(); stim.push_back(8'b10101_001); stim.push_back(8'b00011_010);
        applyStimulus();
        checkVal("keeper assembled", 64'(keeper_pos), 64'(117));
        stim.delete(); stim.push_back(8'b00111_010);
        applyStimulus();
        checkVal("lone keeper high", 64'(keeper_pos), 64'(117));
        checkVal("lone keeper err", 64'(err_cnt), 64'(1));

        stim.delete();
        stim.push_back(8'b01100_011); stim.push_back(8'b01001_100);
        stim.push_back(8'b10000_101); stim.push_back(8'b01100_110);
        applyStimulus();
        checkVal("shot x", 64'(x_shooter), 64'(300));
        checkVal("shot y", 64'(y_shooter), 64'(400));
        stim.delete();
        stim.push_back(8'b00001_011); stim.push_back(8'b00010_101); stim.push_back(8'b00011_110);
        applyStimulus();
        checkVal("partial shot x", 64'(x_shooter), 64'(300));
        checkVal("partial shot err", 64'(err_cnt), 64'(2));

        stim.delete(); stim.push_back(8'b10101_111);
        applyStimulus();
        checkVal("status", 64'({enemy_input, enemy_is_scored, opponent_score}), 64'({1'b1, 1'b0, 3'd5}));

        // Silence until the watchdog trips, then a link-only sync restores the link.
        modelTimeout();
        waitDrain(60);
        checkVal("timeout connect", 64'(connect_corrected), 64'(0));
        stim.delete(); stim.push_back(8'b00001_000);
        applyStimulus();
        checkVal("reconnect", 64'(connect_corrected), 64'(1));

        stim.delete();
        for (int i = 0; i < 6; i++) stim.push_back(8'($urandom));
        base = popLog.size();
        applyStimulus();
        checkVal("burst pop count", 64'(popLog.size() - base), 64'(6));
        badGap = 0;
        for (int i = base + 1; i < base + 6 && i < popLog.size(); i++)
            if (popLog[i] - popLog[i-1] != 3) badGap++;
        checkVal("burst pop spacing", 64'(badGap), 64'(0));

        // Reset pulse while the third byte of a keeper+shot burst is being popped.
        stim.delete();
        addByte(1, 7); addByte(2, 3); addByte(3, 12); addByte(4, 9); addByte(5, 16); addByte(6, 12);
        base = popLog.size();
        pushBytes();
        s = 0;
        forever begin
            @(posedge clk); #2;
            s++;
            if (rd_uart && popLog.size() == base + 2) break;
            if (s > 60) begin
                checks++;
                $display("[TB] FAIL reset window: actual no third pop within 60 cycles, expected one");
                break;
            end
        end
        rst_n = 1'b0;
        #1;
        checkVal("mid reset outputs", 64'(sampleOut()), 64'(0));
        checkVal("mid reset rd_uart", 64'(rd_uart), 64'(0));
        expQ.delete();
        modelReset();
        foreach (fifoQ[i]) modelByte(fifoQ[i]);
        @(posedge clk); #2;
        rst_n = 1'b1;
        waitDrain(60);
        checkVal("reset keeper", 64'(keeper_pos), 64'(0));
        checkVal("post reset shot x", 64'(x_shooter), 64'(300));

        for (int ph = 0; ph < 40; ph++) begin
            stim.delete();
            items = $urandom_range(1, 5);
            for (int i = 0; i < items; i++) begin
                r = $urandom_range(0, 9);
                if (r < 2) begin
                    s = $urandom_range(0, 3);
                    addByte(0, s == 0 ? 25 : s == 1 ? 9 : s == 2 ? 1 : int'($urandom_range(0, 31)));
                end else if (r < 4) begin
                    addByte(3, $urandom_range(0, 31)); addByte(4, $urandom_range(0, 31));
                    addByte(5, $urandom_range(0, 31)); addByte(6, $urandom_range(0, 31));
                end else if (r < 5) begin
                    addByte(1, $urandom_range(0, 31)); addByte(2, $urandom_range(0, 31));
                end else begin
                    addByte($urandom_range(0, 7), $urandom_range(0, 31));
                end
            end
            applyStimulus();
        end

        stim.delete();
        for (int i = 0; i < 300; i++) addByte(6, i);
        applyStimulus();
        checkVal("err saturation", 64'(err_cnt), 64'(255));

        checkVal("scoreboard empty", 64'(expQ.size()), 64'(0));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
